alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU with persistent flags and multi-cycle operations. It accepts one operation per valid/ready handshake and returns a registered result, a high result word and four sticky flags. Add, subtract, logic and single-bit shift/rotate complete in one cycle. Unsigned multiply and shift-by-N are iterative and hold the input interface busy while they run. It sits behind the instruction decoder as the datapath execution unit, and its flags feed the next operation's carry input.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2 to 32.
- CW, $clog2(WIDTH), internal iteration counter width (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operation present on op/a/b.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  4  opcode, see Operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for SHLN, the shift count.
- out_valid  out  1  one-cycle pulse; result/result_hi/flags are valid for the completed operation.
- result  out  WIDTH  low result word; held until the next completion.
- result_hi  out  WIDTH  MUL high word; 0 after every other opcode.
- flags  out  4  {Z,V,R,C}: zero, signed overflow, rotate carry, math carry.

## Operation
- Accept: in_valid & in_ready at a rising edge captures op/a/b. No queueing; in_valid while busy is ignored.
- Opcodes: 0 ADD a+b; 1 ADC a+b+C; 2 SUB a+~b+1; 3 SBC a+~b+C; 4 AND; 5 OR; 6 XOR; 7 PASSB; 8 SHL; 9 SHR (logical); 10 RCL; 11 RCR; 12 MUL (unsigned); 13 SHLN; 14 CLRF; 15 NOP.
- Arithmetic is computed at WIDTH+1 bits. C is the carry out; for SUB/SBC, C=1 means no borrow. V = carry into MSB XOR carry out of MSB.
- Logic/PASSB: C and R are unchanged; V is cleared.
- SHL/SHR shift in 0. RCL/RCR shift in R. R takes the bit shifted out. C is unchanged; V is cleared.
- MUL: iterative shift-add, one partial product per cycle. {result_hi,result} = a*b. C = (result_hi != 0). V and R are unchanged.
- SHLN: n = b mod WIDTH. One left shift per cycle, shifting in 0. R = last bit shifted out; R is unchanged if n=0. C and V are unchanged.
- Z = ({result_hi,result} == 0). Z is updated by every opcode except CLRF and NOP.
- CLRF clears all four flags; result is unchanged. NOP changes nothing. Both still pulse out_valid.
- FSM states:
  - IDLE: on accept, goes to ITER if op is MUL, or SHLN with n>1. Otherwise it completes this edge.
  - ITER: counts iterations. On the last iteration it writes the outputs, pulses out_valid and returns to IDLE.

## Timing
- Reset values: result=0, result_hi=0, flags=0, out_valid=0, in_ready=1, state IDLE, counter 0.
- Single-cycle ops, and SHLN with n<=1: out_valid is high in the cycle after the accepting edge (latency 1). Back-to-back accepts are allowed every cycle.
- MUL: in_ready is low for WIDTH-1 cycles after the accept edge. out_valid rises WIDTH edges after the accept.
- SHLN with n>1: out_valid rises n edges after the accept.
- In the out_valid cycle in_ready is already 1, so a new accept may occur in that same cycle.
- Flag use: ADC/SBC/RCL/RCR use the flag values registered before the accepting edge, including a flag written by the immediately preceding op.
- Asserting rst_n low mid-iteration aborts the operation. All outputs return to their reset values immediately. No out_valid is produced for the aborted op.
- result, result_hi and flags change only on out_valid edges.

## Test plan
- WIDTH=8. ADD 0x7F+0x01 -> result 0x80, C=0, V=1, Z=0, latency 1. Then ADD 0xFF+0x01 -> result 0x00, C=1, V=0, Z=1.
- SUB 0x05-0x07 -> result 0xFE, C=0. Next op SBC 0x10-0x00 -> result 0x0F, C=1 (uses the C from the SUB).
- Load R=1 via SHL 0x80 (result 0x00, R=1). Then RCL 0x80 -> result 0x01, R=1.
- MUL 0xFF*0xFF -> in_ready low for 7 cycles; out_valid 8 edges after accept; result 0x01, result_hi 0xFE, C=1, Z=0. An in_valid pulse mid-run is ignored.
- SHLN a=0x21, b=3 -> out_valid 3 edges after accept, result 0x08, R=1. SHLN with b=8 (n=0) -> result = a, latency 1, R unchanged.
- Start MUL, drop rst_n at iteration 4 -> outputs all 0 immediately, in_ready 1, no out_valid. Then CLRF after flags set -> flags 0, result held, out_valid 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with sticky {Z,V,R,C} flags.
// Single-cycle arithmetic, logic and 1-bit shifts; iterative MUL and SHLN.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADC  = 4'd1,  OP_SUB  = 4'd2,  OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_PASB = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_RCL  = 4'd10, OP_RCR = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12, OP_SHLN = 4'd13, OP_CLRF = 4'd14, OP_NOP = 4'd15;

    // flag bit positions inside {Z,V,R,C}
    localparam int F_Z = 3, F_V = 2, F_R = 1, F_C = 0;

    typedef enum logic {S_IDLE, S_ITER} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       result_q, result_d, hi_q, hi_d;
    logic [3:0]             flags_q, flags_d;
    logic                   ovld_q, ovld_d;
    logic [2*WIDTH-1:0]     p_q, p_d;          // MUL {acc,multiplier} or SHLN shift value (low half)
    logic [WIDTH-1:0]       a_q, a_d;          // latched multiplicand
    logic [CW-1:0]          cnt_q, cnt_d, last_q, last_d;
    logic                   mul_q, mul_d;      // 1: iterating MUL, 0: iterating SHLN

    logic                   accept, iter_last, cin, ovf;
    logic [WIDTH-1:0]       bx, bmod, shl_nxt;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     mul_nxt;

    // one shift-add step: conditionally add multiplicand to the high half, then shift right
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {s, p[WIDTH-1:1]};
    endfunction

    assign accept    = in_valid & in_ready;
    assign iter_last = (cnt_q == last_q);
    assign bmod      = b % WIDTH'(WIDTH);
    assign bx        = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    assign cin       = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : flags_q[F_C];
    assign sum       = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    assign ovf       = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign mul_nxt   = mul_step(p_q, a_q);
    assign shl_nxt   = p_q[WIDTH-1:0] << 1;

    // state register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
            ovld_q   <= 1'b0;
            p_q      <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            mul_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
            ovld_q   <= ovld_d;
            p_q      <= p_d;
            a_q      <= a_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            mul_q    <= mul_d;
        end
    end

    // next state: MUL and SHLN with n>1 iterate, everything else completes on the accept edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && (op == OP_MUL || (op == OP_SHLN && bmod > WIDTH'(1))))
                        state_d = S_ITER;
            S_ITER: if (iter_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath next values; outputs only move on completion
    always_comb begin
        result_d = result_q;
        hi_d     = hi_q;
        flags_d  = flags_q;
        ovld_d   = 1'b0;
        p_d      = p_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        mul_d    = mul_q;
        if (state_q == S_IDLE) begin
            if (accept) begin
                ovld_d = 1'b1;
                hi_d   = '0;
                case (op)
                    OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                        result_d      = sum[WIDTH-1:0];
                        flags_d[F_C]  = sum[WIDTH];
                        flags_d[F_V]  = ovf;
                    end
                    OP_AND:  begin result_d = a & b; flags_d[F_V] = 1'b0; end
                    OP_OR:   begin result_d = a | b; flags_d[F_V] = 1'b0; end
                    OP_XOR:  begin result_d = a ^ b; flags_d[F_V] = 1'b0; end
                    OP_PASB: begin result_d = b;     flags_d[F_V] = 1'b0; end
                    OP_SHL: begin
                        result_d = a << 1;                  flags_d[F_R] = a[WIDTH-1]; flags_d[F_V] = 1'b0;
                    end
                    OP_SHR: begin
                        result_d = a >> 1;                  flags_d[F_R] = a[0];       flags_d[F_V] = 1'b0;
                    end
                    OP_RCL: begin
                        result_d = {a[WIDTH-2:0], flags_q[F_R]}; flags_d[F_R] = a[WIDTH-1]; flags_d[F_V] = 1'b0;
                    end
                    OP_RCR: begin
                        result_d = {flags_q[F_R], a[WIDTH-1:1]}; flags_d[F_R] = a[0];       flags_d[F_V] = 1'b0;
                    end
                    OP_MUL: begin
                        // first partial product is taken on the accept edge
                        ovld_d = 1'b0;
                        hi_d   = hi_q;
                        p_d    = mul_step({{WIDTH{1'b0}}, b}, a);
                        a_d    = a;
                        cnt_d  = '0;
                        last_d = CW'(WIDTH - 2);
                        mul_d  = 1'b1;
                    end
                    OP_SHLN: begin
                        if (bmod == '0) begin
                            result_d = a;
                        end else if (bmod == WIDTH'(1)) begin
                            result_d     = a << 1;
                            flags_d[F_R] = a[WIDTH-1];
                        end else begin
                            ovld_d = 1'b0;
                            hi_d   = hi_q;
                            p_d    = {{WIDTH{1'b0}}, a << 1};
                            cnt_d  = '0;
                            last_d = CW'(bmod - WIDTH'(2));
                            mul_d  = 1'b0;
                        end
                    end
                    OP_CLRF: begin hi_d = hi_q; flags_d = '0; end
                    default: hi_d = hi_q;          // NOP
                endcase
                // Z tracks every completing opcode except CLRF/NOP
                if (ovld_d && op != OP_CLRF && op != OP_NOP)
                    flags_d[F_Z] = ({hi_d, result_d} == '0);
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (mul_q) begin
                p_d = mul_nxt;
                if (iter_last) begin
                    result_d     = mul_nxt[WIDTH-1:0];
                    hi_d         = mul_nxt[2*WIDTH-1:WIDTH];
                    flags_d[F_C] = (mul_nxt[2*WIDTH-1:WIDTH] != '0);
                    flags_d[F_Z] = (mul_nxt == '0);
                    ovld_d       = 1'b1;
                end
            end else begin
                p_d = {{WIDTH{1'b0}}, shl_nxt};
                if (iter_last) begin
                    result_d     = shl_nxt;
                    hi_d         = '0;
                    flags_d[F_R] = p_q[WIDTH-1];
                    flags_d[F_Z] = (shl_nxt == '0);
                    ovld_d       = 1'b1;
                end
            end
        end
    end

    // outputs: ready only while idle, everything else straight from registers
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = ovld_q;
        result    = result_q;
        result_hi = hi_q;
        flags     = flags_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan steps plus random ops against an arithmetic reference model.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk, rst_n, in_valid, in_ready, out_valid;
    logic [3:0]   op, flags;
    logic [W-1:0] a, b, result, result_hi;

    int n_assert = 0;
    int n_fail   = 0;

    // reference state: registered result, high word and {Z,V,R,C}
    int         mres, mhi;
    logic [3:0] mflg;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
        .result_hi(result_hi), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > SMAX) ? x - (1 << W) : x;
    endfunction

    // reference model: updates mres/mhi/mflg and returns expected latency in edges
    task automatic model_op(input logic [3:0] o, input int av, input int bv, output int lat);
        int bx, cin, s, sv, p, n;
        lat = 1;
        case (o)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                bx  = (o >= 4'd2) ? (~bv & MASK) : bv;
                cin = (o == 4'd0) ? 0 : (o == 4'd2) ? 1 : int'(mflg[0]);
                s   = av + bx + cin;
                sv  = sgn(av) + sgn(bx) + cin;
                mres = s & MASK; mhi = 0;
                mflg[0] = (s > MASK);
                mflg[2] = (sv > SMAX) || (sv < SMIN);
            end
            4'd4: begin mres = av & bv; mhi = 0; mflg[2] = 1'b0; end
            4'd5: begin mres = av | bv; mhi = 0; mflg[2] = 1'b0; end
            4'd6: begin mres = av ^ bv; mhi = 0; mflg[2] = 1'b0; end
            4'd7: begin mres = bv;      mhi = 0; mflg[2] = 1'b0; end
            4'd8: begin mres = (av << 1) & MASK; mhi = 0; mflg[1] = av[W-1]; mflg[2] = 1'b0; end
            4'd9: begin mres = av >> 1;          mhi = 0; mflg[1] = av[0];   mflg[2] = 1'b0; end
            4'd10: begin
                mres = ((av << 1) | int'(mflg[1])) & MASK; mhi = 0; mflg[1] = av[W-1]; mflg[2] = 1'b0;
            end
            4'd11: begin
                mres = (av >> 1) | (int'(mflg[1]) << (W - 1)); mhi = 0; mflg[1] = av[0]; mflg[2] = 1'b0;
            end
            4'd12: begin
                p = av * bv; mres = p & MASK; mhi = p >> W; mflg[0] = (mhi != 0); lat = W;
            end
            4'd13: begin
                n = bv % W; mres = (av << n) & MASK; mhi = 0;
                if (n > 0) mflg[1] = av[W-n];
                lat = (n > 1) ? n : 1;
            end
            4'd14: mflg = 4'b0000;
            default: ;
        endcase
        if (o < 4'd14) mflg[3] = (mres == 0 && mhi == 0);
    endtask

    // issue one op at a negedge with in_ready high; return at the negedge of its out_valid cycle
    task automatic do_op(input logic [3:0] o, input int av, input int bv, input bit inj);
        int         lat, edges;
        logic [19:0] held;
        held = {mres[7:0], mhi[7:0], mflg};
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = av[W-1:0]; b = bv[W-1:0];
        model_op(o, av, bv, lat);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; edges = 1;
        while (out_valid !== 1'b1 && edges < 64) begin
            check("busy_ready_low", 32'(in_ready), 32'd0);
            check("outputs_held_while_busy", 32'({result, result_hi, flags}), 32'(held));
            if (inj && in_ready === 1'b0) begin
                in_valid = 1'b1; op = 4'($urandom_range(0, 15));
                a = W'($urandom); b = W'($urandom);
            end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0; edges++;
        end
        check("latency", 32'(edges), 32'(lat));
        check("result", 32'(result), 32'(mres));
        check("result_hi", 32'(result_hi), 32'(mhi));
        check("flags", 32'(flags), 32'(mflg));
        check("ready_in_done_cycle", 32'(in_ready), 32'd1);
    endtask

    // constant expectations for the directed test-plan steps
    task automatic tp(input string tag, input logic [7:0] r, input logic [7:0] h, input logic [3:0] f);
        check(tag, 32'({result, result_hi, flags}), 32'({r, h, f}));
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; a = '0; b = '0;
        mres = 0; mhi = 0; mflg = 4'b0000;
        #3;
        check("reset_state", 32'({out_valid, in_ready, result, result_hi, flags}), 32'({1'b0, 1'b1, 20'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed test-plan steps (flags are {Z,V,R,C})
        do_op(4'd0, 'h7F, 'h01, 0);  tp("add_7f_01", 8'h80, 8'h00, 4'b0100);
        do_op(4'd0, 'hFF, 'h01, 0);  tp("add_ff_01", 8'h00, 8'h00, 4'b1001);
        do_op(4'd2, 'h05, 'h07, 0);  tp("sub_05_07", 8'hFE, 8'h00, 4'b0000);
        do_op(4'd3, 'h10, 'h00, 0);  tp("sbc_10_00", 8'h0F, 8'h00, 4'b0001);
        do_op(4'd8, 'h80, 'h00, 0);  tp("shl_80",    8'h00, 8'h00, 4'b1011);
        do_op(4'd10, 'h80, 'h00, 0); tp("rcl_80",    8'h01, 8'h00, 4'b0011);
        do_op(4'd12, 'hFF, 'hFF, 1); tp("mul_ff_ff", 8'h01, 8'hFE, 4'b0011);
        do_op(4'd13, 'h21, 'h03, 0); tp("shln_21_3", 8'h08, 8'h00, 4'b0011);
        do_op(4'd13, 'h5A, 'h08, 0); tp("shln_n0",   8'h5A, 8'h00, 4'b0011);

        // abort a MUL with reset mid-iteration
        in_valid = 1'b1; op = 4'd12; a = 8'h12; b = 8'h34;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_busy_before_abort", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({out_valid, in_ready, result, result_hi, flags}), 32'({1'b0, 1'b1, 20'h0}));
        mres = 0; mhi = 0; mflg = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        check("abort_no_out_valid", 32'(pulses), 32'd0);

        do_op(4'd0, 'hFF, 'h02, 0);  tp("add_ff_02", 8'h01, 8'h00, 4'b0001);
        do_op(4'd14, 'h00, 'h00, 0); tp("clrf",      8'h01, 8'h00, 4'b0000);
        @(negedge clk);
        check("out_valid_one_cycle", 32'(out_valid), 32'd0);

        // random ops, some with ignored mid-run in_valid and idle gaps
        for (int i = 0; i < 160; i++) begin
            do_op(4'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
                  int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("idle_no_out_valid", 32'(out_valid), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
